// File: rtl/key_entry_ctrl_pkg.sv
// Purpose: shared keypad definitions (key codes, FSM encodings, key classifier).
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package key_entry_ctrl_pkg;

  // Special key codes from the keypad scanner
  localparam logic [3:0] KEY_BKSP = 4'd10;
  localparam logic [3:0] KEY_CLR  = 4'd11;
  localparam logic [3:0] KEY_ENT  = 4'd15;

  // Entry FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENTRY = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  typedef enum logic [2:0] {
    KC_DIGIT,
    KC_BKSP,
    KC_CLR,
    KC_ENT,
    KC_NONE
  } key_class_e;

  // Committed entry: BCD nibbles (newest in [3:0]) plus digit count
  typedef struct packed {
    logic [15:0] dat;
    logic [2:0]  cnt;
  } entry_t;

  function automatic key_class_e classify(input logic [3:0] code);
    key_class_e kc;
    if (code <= 4'd9)           kc = KC_DIGIT;
    else if (code == KEY_BKSP)  kc = KC_BKSP;
    else if (code == KEY_CLR)   kc = KC_CLR;
    else if (code == KEY_ENT)   kc = KC_ENT;
    else                        kc = KC_NONE;
    return kc;
  endfunction

endpackage

// File: rtl/key_entry_ctrl_edge.sv
// Purpose: 2-flop synchroniser plus rising-edge detect for the scanner key flag.
// Latency: key_evt is high in the cycle after the 2nd sync flop captures the flag.
// Backpressure: none; one single-cycle event per rising edge.
// Ports: clk, rst (sync, active-high), key_flag (async in), key_evt (1-cycle event).
module key_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic key_flag,
  output logic key_evt
);

  logic sync1, sync2, sync3;
  logic prime1, prime2;
  logic armed;

  // prime1/prime2 mark that sync2 holds a genuine post-reset sample. The
  // detector only arms once that sample is low, so a flag already held high
  // across reset release cannot masquerade as a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      prime1 <= 1'b0;
      prime2 <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sync1  <= key_flag;
      sync2  <= sync1;
      sync3  <= sync2;
      prime1 <= 1'b1;
      prime2 <= prime1;
      armed  <= armed | (prime2 & ~sync2);
    end
  end

  assign key_evt = armed & sync2 & ~sync3;

endmodule

// File: rtl/key_entry_ctrl.sv
// Purpose: keypad digit-entry controller: buffers up to 4 BCD digits, commits on enter.
// Latency: outputs reflect a key on the 3rd clk edge that samples key_flag high.
// Backpressure: committed value held with value_valid until value_ready; keys meanwhile are dropped with err.
// Ports: clk, rst; key_flag/key_data from scanner; digits/digit_cnt live buffer;
//        value/value_cnt/value_valid/value_ready commit handshake; err, timeout pulses.
module key_entry_ctrl
  import key_entry_ctrl_pkg::*;
#(
  parameter int MAX_DIGITS  = 4,
  parameter int TIMEOUT_CYC = 250_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_flag,
  input  logic [3:0]  key_data,
  output logic [15:0] digits,
  output logic [2:0]  digit_cnt,
  output logic        value_valid,
  output logic [15:0] value,
  output logic [2:0]  value_cnt,
  input  logic        value_ready,
  output logic        err,
  output logic        timeout
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic             key_evt;
  key_class_e       kc;
  logic [1:0]       state, state_n;
  logic [15:0]      digits_n;
  logic [2:0]       cnt_n;
  entry_t           cmt, cmt_n;
  logic             vld_n, err_n, to_n;
  logic [TMR_W-1:0] timer, timer_n;

  key_edge_sync u_edge (
    .clk      (clk),
    .rst      (rst),
    .key_flag (key_flag),
    .key_evt  (key_evt)
  );

  assign kc = classify(key_data);

  always_comb begin
    state_n  = state;
    digits_n = digits;
    cnt_n    = digit_cnt;
    cmt_n    = cmt;
    vld_n    = value_valid;
    err_n    = 1'b0;
    to_n     = 1'b0;
    timer_n  = '0;

    case (state)
      ST_IDLE, ST_ENTRY: begin
        if (key_evt) begin
          // Every event, accepted or rejected, restarts the inactivity timer.
          unique case (kc)
            KC_DIGIT: begin
              if (digit_cnt < 3'(MAX_DIGITS)) begin
                digits_n = {digits[11:0], key_data};
                cnt_n    = digit_cnt + 3'd1;
                state_n  = ST_ENTRY;
              end else begin
                err_n = 1'b1;
              end
            end
            KC_BKSP: begin
              if (state == ST_IDLE) begin
                err_n = 1'b1;
              end else begin
                digits_n = {4'h0, digits[15:4]};
                cnt_n    = digit_cnt - 3'd1;
                if (digit_cnt == 3'd1) state_n = ST_IDLE;
              end
            end
            KC_CLR: begin
              digits_n = '0;
              cnt_n    = '0;
              state_n  = ST_IDLE;
            end
            KC_ENT: begin
              if (state == ST_IDLE) begin
                err_n = 1'b1;
              end else begin
                cmt_n.dat = digits;
                cmt_n.cnt = digit_cnt;
                vld_n     = 1'b1;
                digits_n  = '0;
                cnt_n     = '0;
                state_n   = ST_OUT;
              end
            end
            default: ;
          endcase
        end else if (state == ST_ENTRY) begin
          // A key in the expiry cycle wins (handled above), so this is a pure timeout.
          if (timer == TMR_LAST) begin
            digits_n = '0;
            cnt_n    = '0;
            state_n  = ST_IDLE;
            to_n     = 1'b1;
          end else begin
            timer_n = timer + TMR_W'(1);
          end
        end
      end
      ST_OUT: begin
        if (value_ready) begin
          vld_n   = 1'b0;
          state_n = ST_IDLE;
        end
        // Keys are never buffered while a commit is pending, even on the handoff cycle.
        if (key_evt) err_n = 1'b1;
      end
      default: begin
        digits_n = '0;
        cnt_n    = '0;
        vld_n    = 1'b0;
        state_n  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      digits      <= '0;
      digit_cnt   <= '0;
      cmt         <= '0;
      value_valid <= 1'b0;
      err         <= 1'b0;
      timeout     <= 1'b0;
      timer       <= '0;
    end else begin
      state       <= state_n;
      digits      <= digits_n;
      digit_cnt   <= cnt_n;
      cmt         <= cmt_n;
      value_valid <= vld_n;
      err         <= err_n;
      timeout     <= to_n;
      timer       <= timer_n;
    end
  end

  assign value     = cmt.dat;
  assign value_cnt = cmt.cnt;

endmodule

// File: tb/tb_key_entry_ctrl.sv
module tb_key_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_flag;
  logic [3:0]  key_data;
  logic [15:0] digits;
  logic [2:0]  digit_cnt;
  logic        value_valid;
  logic [15:0] value;
  logic [2:0]  value_cnt;
  logic        value_ready;
  logic        err;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_entry_ctrl #(
    .MAX_DIGITS  (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_flag    (key_flag),
    .key_data    (key_data),
    .digits      (digits),
    .digit_cnt   (digit_cnt),
    .value_valid (value_valid),
    .value       (value),
    .value_cnt   (value_cnt),
    .value_ready (value_ready),
    .err         (err),
    .timeout     (timeout)
  );

  typedef struct {
    string       name;
    logic [3:0]  key;
    logic        rdy;
    logic [15:0] dig;
    logic [2:0]  cnt;
    logic        e;
    logic        vld;
    logic [15:0] val;
    logic [2:0]  vcnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic [3:0] k, input logic r,
                     input logic [15:0] d, input logic [2:0] c, input logic e,
                     input logic v, input logic [15:0] vl, input logic [2:0] vc);
    vec_t t;
    t.name = nm; t.key = k; t.rdy = r; t.dig = d; t.cnt = c;
    t.e = e; t.vld = v; t.val = vl; t.vcnt = vc;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Raise the flag, wait for the event edge (3rd edge sampling it), release.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_data = k;
    key_flag = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    key_flag = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    logic [15:0] cap_v;
    logic [2:0]  cap_c;
    int act;

    rst = 1'b1; key_flag = 1'b0; key_data = 4'd0; value_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", 32'(digits), 0);
    chk("rst_cnt", 32'(digit_cnt), 0);
    chk("rst_vld", 32'(value_valid), 0);
    chk("rst_value", 32'(value), 0);
    chk("rst_vcnt", 32'(value_cnt), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_timeout", 32'(timeout), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    //   name     key    rdy   digits    cnt  err  vld  value     vcnt
    add("d9",     4'd9,  1'b0, 16'h0009, 3'd1, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("d8",     4'd8,  1'b0, 16'h0098, 3'd2, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("d7",     4'd7,  1'b0, 16'h0987, 3'd3, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("d6",     4'd6,  1'b0, 16'h9876, 3'd4, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("d5_full",4'd5,  1'b0, 16'h9876, 3'd4, 1'b1, 1'b0, 16'h0000, 3'd0);
    add("clr",    4'd11, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("clr_mt", 4'd11, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("d4",     4'd4,  1'b0, 16'h0004, 3'd1, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("d5",     4'd5,  1'b0, 16'h0045, 3'd2, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("bk1",    4'd10, 1'b0, 16'h0004, 3'd1, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("bk2",    4'd10, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("bk3_mt", 4'd10, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 16'h0000, 3'd0);
    add("ign12",  4'd12, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("ent_mt", 4'd15, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 16'h0000, 3'd0);
    add("d2",     4'd2,  1'b0, 16'h0002, 3'd1, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("ign13",  4'd13, 1'b0, 16'h0002, 3'd1, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("clr2",   4'd11, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("d1",     4'd1,  1'b0, 16'h0001, 3'd1, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("d2b",    4'd2,  1'b0, 16'h0012, 3'd2, 1'b0, 1'b0, 16'h0000, 3'd0);
    add("ent",    4'd15, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1, 16'h0012, 3'd2);
    add("out_k7", 4'd7,  1'b0, 16'h0000, 3'd0, 1'b1, 1'b1, 16'h0012, 3'd2);
    add("out_rdy",4'd4,  1'b1, 16'h0000, 3'd0, 1'b1, 1'b0, 16'h0012, 3'd2);
    add("idle_d3",4'd3,  1'b0, 16'h0003, 3'd1, 1'b0, 1'b0, 16'h0012, 3'd2);
    add("clr3",   4'd11, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0012, 3'd2);

    foreach (vq[i]) begin
      @(negedge clk);
      key_data = vq[i].key;
      key_flag = 1'b1;
      repeat (2) @(posedge clk);
      // value_ready changes only in the event cycle so it coincides with the key.
      @(negedge clk);
      value_ready = vq[i].rdy;
      @(posedge clk);
      #1;
      chk({vq[i].name, "_digits"}, 32'(digits), 32'(vq[i].dig));
      chk({vq[i].name, "_cnt"},    32'(digit_cnt), 32'(vq[i].cnt));
      chk({vq[i].name, "_err"},    32'(err), 32'(vq[i].e));
      chk({vq[i].name, "_vld"},    32'(value_valid), 32'(vq[i].vld));
      chk({vq[i].name, "_value"},  32'(value), 32'(vq[i].val));
      chk({vq[i].name, "_vcnt"},   32'(value_cnt), 32'(vq[i].vcnt));
      @(negedge clk);
      key_flag = 1'b0;
      repeat (4) @(posedge clk);
    end

    // 1,2,3,ENT with value_ready held high: one-cycle valid carrying 0123/3
    @(negedge clk);
    value_ready = 1'b1;
    press(4'd1);
    press(4'd2);
    press(4'd3);
    @(negedge clk);
    key_data = 4'd15;
    key_flag = 1'b1;
    n = 0; cap_v = 16'h0; cap_c = 3'd0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (value_valid) begin
        n++;
        cap_v = value;
        cap_c = value_cnt;
      end
      if (i == 3) key_flag = 1'b0;
    end
    chk("hs_valid_cycles", 32'(n), 1);
    chk("hs_value", 32'(cap_v), 32'h0123);
    chk("hs_vcnt", 32'(cap_c), 3);
    @(negedge clk);
    value_ready = 1'b0;

    // Inactivity: key 3 then nothing; timeout 100 cycles after the event edge
    @(negedge clk);
    key_data = 4'd3;
    key_flag = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("to_start_cnt", 32'(digit_cnt), 1);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 150 && !seen; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (i == 1) key_flag = 1'b0;
      if (timeout) seen = 1'b1;
    end
    chk("to_seen", 32'(seen), 1);
    chk("to_delay", 32'(n), 100);
    chk("to_digits", 32'(digits), 0);
    chk("to_cnt", 32'(digit_cnt), 0);
    @(posedge clk);
    #1;
    chk("to_pulse_width", 32'(timeout), 0);

    // Reset mid-entry with key_flag held high across reset release
    press(4'd1);
    chk("rstk_pre_cnt", 32'(digit_cnt), 1);
    @(negedge clk);
    key_data = 4'd5;
    key_flag = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    act = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (err || timeout || value_valid || digit_cnt != 3'd0 || digits != 16'h0) act++;
    end
    chk("rstk_quiet_cycles", 32'(act), 0);
    chk("rstk_digits", 32'(digits), 0);
    chk("rstk_cnt", 32'(digit_cnt), 0);
    chk("rstk_value", 32'(value), 0);
    chk("rstk_vcnt", 32'(value_cnt), 0);
    @(negedge clk);
    key_flag = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    key_flag = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rstk_new_digits", 32'(digits), 32'h0005);
    chk("rstk_new_cnt", 32'(digit_cnt), 1);
    @(negedge clk);
    key_flag = 1'b0;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_entry_ctrl.md
KEY_ENTRY_CTRL -- requirements
Module: key_entry_ctrl

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 4, meaning the digit buffer depth; only the value 4 is supported.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 250_000_000, meaning the inactivity limit in clk cycles (5 s at 50 MHz).
REQ-003 SHALL have port clk, input, 1 bit: system clock, 50 MHz; the only clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port key_flag, input, 1 bit: key-captured flag from the keypad scanner; asynchronous to clk decoding, high for one or more scanner ticks.
REQ-006 SHALL have port key_data, input, 4 bits: key code 0-15, stable while key_flag is high.
REQ-007 SHALL have port digits, output, 16 bits: BCD entry buffer; [3:0] holds the newest digit; unused nibbles are 0.
REQ-008 SHALL have port digit_cnt, output, 3 bits: number of digits held, 0-4.
REQ-009 SHALL have port value_valid, output, 1 bit: a committed entry is available.
REQ-010 SHALL have port value, output, 16 bits: committed BCD entry, same layout as digits.
REQ-011 SHALL have port value_cnt, output, 3 bits: digit count of the committed entry.
REQ-012 SHALL have port value_ready, input, 1 bit: consumer accepts the committed entry.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse flagging a rejected key.
REQ-014 SHALL have port timeout, output, 1 bit: one-cycle pulse flagging an inactivity clear.

Function
REQ-015 SHALL synchronise key_flag through 2 flops and detect its rising edge with a third flop; one key event occurs per rising edge.
REQ-016 SHALL sample key_data in the cycle the event is detected; outputs SHALL reflect the key 3 clk cycles after key_flag is first sampled high.
REQ-017 SHALL decode key codes as follows: 0-9 digit, 10 backspace, 11 clear, 15 enter, 12-14 ignored (no err).
REQ-018 SHALL implement the FSM states IDLE (digit_cnt=0), ENTRY (digit_cnt 1-4) and OUT (value_valid=1).
REQ-019 SHALL, on a digit in IDLE or ENTRY with digit_cnt<4, set digits to {digits[11:0], key}, increment digit_cnt, and go to ENTRY.
REQ-020 SHALL, on a digit with digit_cnt=4, leave the buffer unchanged and pulse err.
REQ-021 SHALL, on backspace, set digits to {4'h0, digits[15:4]} and decrement digit_cnt; on reaching 0 it SHALL go to IDLE.
REQ-022 SHALL, on backspace in IDLE, pulse err and change nothing else.
REQ-023 SHALL, on clear, zero digits and digit_cnt and go to IDLE, with no err even when already empty.
REQ-024 SHALL, on enter in ENTRY, copy digits and digit_cnt to value and value_cnt, set value_valid, zero the buffer, and go to OUT.
REQ-025 SHALL, on enter in IDLE, pulse err and produce no output.
REQ-026 SHALL, in OUT, hold value, value_cnt and value_valid stable until value_ready=1; on that cycle it SHALL drop value_valid and go to IDLE.
REQ-027 SHALL, in OUT, drop any key event and pulse err; when a key event coincides with value_ready, the transfer completes and the key is dropped with err.
REQ-028 SHALL count an inactivity timer only in ENTRY, restarting it at every key event, including rejected ones.
REQ-029 SHALL, when the timer reaches TIMEOUT_CYC-1, clear the buffer, go to IDLE and pulse timeout; a key event in that same cycle takes precedence and restarts the timer.
REQ-030 SHALL drive all outputs from registers.

Reset
REQ-031 SHALL, while rst=1 at a clk edge, put the FSM in IDLE and zero digits, digit_cnt, value, value_cnt, value_valid, err, timeout, the timer and all sync/edge flops.
REQ-032 SHALL, on rst mid-entry or in OUT, discard pending data without emitting err or timeout.
REQ-033 SHALL NOT generate an event from a key_flag that is already high when rst releases; such a key needs a new rising edge.

Structure
REQ-034 SHALL take the key codes (KEY_BKSP=10, KEY_CLR=11, KEY_ENT=15) and the FSM state encodings from the shared keypad package.
REQ-035 SHALL instantiate one sub-module, key_edge_sync, holding the 2-flop sync and rising-edge detect.

Verification
REQ-036 Bench SHALL drive keys 1, 2, 3, ENT with value_ready=1 and require value=16'h0123, value_cnt=3, value_valid for exactly 1 cycle.
REQ-037 Bench SHALL drive keys 9, 8, 7, 6, 5 and require digits=16'h9876, digit_cnt=4, and one err pulse on the 5th key.
REQ-038 Bench SHALL drive keys 4, 5, BKSP, then BKSP twice more and require digits=16'h0004, then 16'h0000 in IDLE, and err on the third BKSP.
REQ-039 Bench SHALL drive ENT then 7 while value_ready=0 and require value_valid held, value stable and err pulsed; raising value_ready SHALL return the FSM to IDLE.
REQ-040 Bench SHALL run with TIMEOUT_CYC=100, enter key 3 and then idle, and require a timeout pulse 100 cycles after the event with digits=0.
REQ-041 Bench SHALL assert rst during ENTRY with key_flag held high and require all outputs zero and no event until key_flag toggles low then high.
